// File: rtl/reduce_pkg.sv
// Shared types and helpers for the pairwise reduction tree controller.
// Build option REDUCE_SAT_EN selects saturating adds and exposes sat_o.
package reduce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_DONE
  } state_e;

  // Element width derived from the base word length.
  function automatic int unsigned W(input int unsigned xlen);
    return xlen * 2 + 1;
  endfunction

endpackage

// File: rtl/reduce_tree_ctrl_if.sv
// Operand/result handshake bundle for reduce_tree_ctrl.
// sat_o exists only when REDUCE_SAT_EN is defined.
interface reduce_tree_ctrl_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NrInputs = 32
) ();
  import reduce_pkg::*;

  localparam int unsigned ElemW = W(XLEN);
  localparam int unsigned PassW = $clog2(NrInputs) + 1;

  logic             en_i;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [ElemW-1:0] a_i [NrInputs];
  logic             out_valid_o;
  logic             out_ready_i;
  logic [ElemW-1:0] result_o;
  logic             busy_o;
  logic [PassW-1:0] pass_o;
`ifdef REDUCE_SAT_EN
  logic             sat_o;
`endif

  modport slave (
    input  en_i, flush_i, in_valid_i, a_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, busy_o, pass_o
`ifdef REDUCE_SAT_EN
    , output sat_o
`endif
  );

  modport master (
    output en_i, flush_i, in_valid_i, a_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, busy_o, pass_o
`ifdef REDUCE_SAT_EN
    , input sat_o
`endif
  );

endinterface

// File: rtl/reduce_pair_stage.sv
// Combinational pairwise adder array: sum_o[k] = pairs_i[2k] + pairs_i[2k+1].
// REDUCE_SAT_EN: each add saturates to all-ones on carry-out and flags it.
module reduce_pair_stage
  import reduce_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NrInputs = 32
) (
  input  logic [W(XLEN)-1:0] pairs_i [NrInputs],
  output logic [W(XLEN)-1:0] sum_o   [NrInputs/2]
`ifdef REDUCE_SAT_EN
  , output logic [NrInputs/2-1:0] sat_o
`endif
);

  localparam int unsigned ElemW = W(XLEN);

`ifdef REDUCE_SAT_EN
  logic [ElemW:0] wide;

  always_comb begin
    wide  = '0;
    sat_o = '0;
    for (int unsigned k = 0; k < NrInputs / 2; k++) begin
      wide     = {1'b0, pairs_i[2*k]} + {1'b0, pairs_i[2*k+1]};
      sat_o[k] = wide[ElemW];
      sum_o[k] = wide[ElemW] ? '1 : wide[ElemW-1:0];
    end
  end
`else
  always_comb begin
    for (int unsigned k = 0; k < NrInputs / 2; k++) begin
      sum_o[k] = pairs_i[2*k] + pairs_i[2*k+1];
    end
  end
`endif

endmodule

// File: rtl/reduce_tree_ctrl.sv
// Iterative reduction controller: accepts an operand vector, halves it each
// enabled cycle with reduce_pair_stage, then presents buf[0]. Option: REDUCE_SAT_EN.
module reduce_tree_ctrl
  import reduce_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NrInputs = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  reduce_tree_ctrl_if.slave bus
);

  localparam int unsigned ElemW = W(XLEN);
  localparam int unsigned CntW  = $clog2(NrInputs) + 1;
  localparam int unsigned PassW = $clog2(NrInputs) + 1;
  localparam int unsigned Half  = NrInputs / 2;

  state_e           state_q, state_d;
  logic [ElemW-1:0] buf_q [NrInputs];
  logic [ElemW-1:0] buf_d [NrInputs];
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PassW-1:0] pass_q, pass_d;
  logic [ElemW-1:0] sum [Half];
  logic [Half-1:0]  act_mask;
  logic [CntW-1:0]  cnt_half;

`ifdef REDUCE_SAT_EN
  logic             sat_q, sat_d;
  logic [Half-1:0]  sat_vec;
`endif

  reduce_pair_stage #(
    .XLEN     (XLEN),
    .NrInputs (NrInputs)
  ) u_pair_stage (
    .pairs_i (buf_q),
    .sum_o   (sum)
`ifdef REDUCE_SAT_EN
    , .sat_o (sat_vec)
`endif
  );

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
`ifdef REDUCE_SAT_EN
    sat_d    = sat_q;
`endif
    cnt_half = cnt_q >> 1;
    act_mask = '0;
    for (int unsigned k = 0; k < Half; k++) begin
      act_mask[k] = (k < int'(cnt_half));
    end

    // Flush wins over every other input, including a pending DONE result.
    if (bus.flush_i) begin
      state_d = ST_IDLE;
      for (int unsigned i = 0; i < NrInputs; i++) begin
        buf_d[i] = '0;
      end
      cnt_d  = '0;
      pass_d = '0;
`ifdef REDUCE_SAT_EN
      sat_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid_i && bus.en_i) begin
            buf_d   = bus.a_i;
            cnt_d   = CntW'(NrInputs);
            pass_d  = '0;
`ifdef REDUCE_SAT_EN
            sat_d   = 1'b0;
`endif
            state_d = ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          if (bus.en_i) begin
            for (int unsigned k = 0; k < Half; k++) begin
              if (act_mask[k]) buf_d[k] = sum[k];
            end
            cnt_d  = cnt_half;
            pass_d = pass_q + PassW'(1);
`ifdef REDUCE_SAT_EN
            sat_d  = sat_q | (|(sat_vec & act_mask));
`endif
            if (cnt_half == CntW'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      for (int unsigned i = 0; i < NrInputs; i++) begin
        buf_q[i] <= '0;
      end
      cnt_q   <= '0;
      pass_q  <= '0;
`ifdef REDUCE_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
`ifdef REDUCE_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign bus.in_ready_o  = (state_q == ST_IDLE) && bus.en_i;
  assign bus.out_valid_o = (state_q == ST_DONE);
  assign bus.result_o    = (state_q == ST_DONE) ? buf_q[0] : '0;
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.pass_o      = pass_q;
`ifdef REDUCE_SAT_EN
  assign bus.sat_o       = sat_q;
`endif

endmodule
